// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store requester and the data memory.
// One request outstanding; each channel uses a valid/ready handshake.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with fixed accept-to-response latency.
// Single outstanding request: IDLE -> BUSY (countdown) -> RESP -> IDLE.
module data_mem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 16384
) (
    input  logic      clk,
    input  logic      reset_n,
    data_mem_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [30:0] DEPTH_LIM = 31'(DEPTH_WORDS);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic          access;
    logic          waiting;
    logic          consume;
    logic          addr_err;
    logic          do_store;
    logic [AW-1:0] widx;

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign access  = (state_q == BUSY) && (cnt_q == 4'd0);
    assign waiting = (state_q == BUSY) && (cnt_q != 4'd0);
    assign consume = (state_q == RESP) && bus.resp_ready;

    assign addr_err = (addr_q[1:0] != 2'b00) ||
                      ({1'b0, addr_q[31:2]} >= DEPTH_LIM);
    assign widx     = addr_q[AW+1:2];
    assign do_store = access && write_q && !addr_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (1'b1)
            accept: begin
                state_d = BUSY;
                cnt_d   = CNT_INIT;
            end
            access: begin
                state_d = RESP;
                err_d   = addr_err;
                rdata_d = (addr_err || write_q) ? 32'd0 : mem_q[widx];
            end
            waiting: begin
                cnt_d = cnt_q - 4'd1;
            end
            consume: begin
                state_d = IDLE;
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    // Storage survives reset; an aborted store never reaches its access edge.
    always_ff @(posedge clk) begin
        if (do_store) begin
            mem_q[widx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, corner sequences,
// and randomized traffic against a word-array reference model.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    data_mem_if bus1();
    data_mem_if bus2();

    data_mem_responder #(.LATENCY(4), .DEPTH_WORDS(16384)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
    );

    data_mem_responder #(.LATENCY(1), .DEPTH_WORDS(16384)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave)
    );

    int total = 0;
    int passed = 0;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        xerr;
        logic [31:0] xrd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b, expected %b", nm, act, exp);
    endtask

    // One LATENCY=4 transaction on dut1, with optional response stall.
    task automatic txn(input string nm, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic xerr,
                       input logic [31:0] xrd, input int hold, input bit spur);
        int lat;
        @(negedge clk);
        chk1({nm, ".req_ready"}, bus1.req_ready, 1'b1);
        bus1.req_valid = 1'b1;
        bus1.req_write = wr;
        bus1.req_addr  = a;
        bus1.req_wdata = d;
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        lat = 0;
        while (bus1.resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, ".latency"}, 32'(lat), 32'd4);
        chk1({nm, ".err"}, bus1.resp_err, xerr);
        chk({nm, ".rdata"}, bus1.resp_rdata, xrd);
        for (int i = 0; i < hold; i++) begin
            if (spur) begin
                @(negedge clk);
                bus1.req_valid = 1'b1;
                bus1.req_write = 1'b1;
                bus1.req_addr  = 32'h10;
                bus1.req_wdata = 32'h9999_9999;
            end
            @(posedge clk); #1;
            chk1({nm, ".hold_valid"}, bus1.resp_valid, 1'b1);
            chk({nm, ".hold_rdata"}, bus1.resp_rdata, xrd);
            chk1({nm, ".hold_err"}, bus1.resp_err, xerr);
            chk1({nm, ".hold_ready"}, bus1.req_ready, 1'b0);
        end
        @(negedge clk);
        bus1.req_valid  = 1'b0;
        bus1.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus1.resp_ready = 1'b0;
        chk1({nm, ".done_valid"}, bus1.resp_valid, 1'b0);
        chk({nm, ".done_rdata"}, bus1.resp_rdata, 32'd0);
        chk1({nm, ".done_ready"}, bus1.req_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[$];
    logic [31:0] model [8];
    logic [31:0] a, d, xrd;
    logic        wr, xerr;
    int          idx, sel, w;

    initial begin
        bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = 0;
        bus1.req_wdata = 0; bus1.resp_ready = 0;
        bus2.req_valid = 0; bus2.req_write = 0; bus2.req_addr = 0;
        bus2.req_wdata = 0; bus2.resp_ready = 1;

        #1;
        chk1("rst.ready1", bus1.req_ready, 1'b1);
        chk1("rst.valid1", bus1.resp_valid, 1'b0);
        chk("rst.rdata1", bus1.resp_rdata, 32'd0);
        chk1("rst.err1", bus1.resp_err, 1'b0);
        chk1("rst.ready2", bus2.req_ready, 1'b1);
        chk1("rst.valid2", bus2.resp_valid, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        vecs = '{
            '{"st_10",      1'b1, 32'h10,         32'hDEAD_BEEF, 1'b0, 32'h0},
            '{"ld_10",      1'b0, 32'h10,         32'h0,         1'b0, 32'hDEAD_BEEF},
            '{"ld_13_mis",  1'b0, 32'h13,         32'h0,         1'b1, 32'h0},
            '{"ld_oor",     1'b0, 32'h0001_0000,  32'h0,         1'b1, 32'h0},
            '{"st_13_mis",  1'b1, 32'h13,         32'h1111_1111, 1'b1, 32'h0},
            '{"ld_10_kept", 1'b0, 32'h10,         32'h0,         1'b0, 32'hDEAD_BEEF},
            '{"st_last",    1'b1, 32'h0000_FFFC,  32'hCAFE_F00D, 1'b0, 32'h0},
            '{"ld_last",    1'b0, 32'h0000_FFFC,  32'h0,         1'b0, 32'hCAFE_F00D},
            '{"st_20",      1'b1, 32'h20,         32'hA5A5_A5A5, 1'b0, 32'h0},
            '{"ld_20",      1'b0, 32'h20,         32'h0,         1'b0, 32'hA5A5_A5A5},
            '{"st_hi_oor",  1'b1, 32'h8000_0000,  32'h7777_7777, 1'b1, 32'h0},
            '{"ld_12_mis",  1'b0, 32'h12,         32'h0,         1'b1, 32'h0},
            '{"st_0",       1'b1, 32'h0,          32'h0000_0001, 1'b0, 32'h0},
            '{"ld_0",       1'b0, 32'h0,          32'h0,         1'b0, 32'h0000_0001}
        };
        foreach (vecs[i])
            txn(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].xerr, vecs[i].xrd, 0, 1'b0);

        // Stall the response and throw ignored requests at it.
        txn("stall_ld_10", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 5, 1'b1);
        txn("after_spur", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);

        // Reset two edges after accepting a store.
        @(negedge clk);
        bus1.req_valid = 1; bus1.req_write = 1;
        bus1.req_addr = 32'h20; bus1.req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus1.req_valid = 0;
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk1("abort_busy.valid", bus1.resp_valid, 1'b0);
        chk1("abort_busy.ready", bus1.req_ready, 1'b1);
        chk("abort_busy.rdata", bus1.resp_rdata, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        txn("ld_20_after_abort", 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5_A5A5, 0, 1'b0);

        // Reset while a load response is pending.
        @(negedge clk);
        bus1.req_valid = 1; bus1.req_write = 0; bus1.req_addr = 32'h10;
        @(posedge clk); #1;
        bus1.req_valid = 0;
        w = 0;
        while (bus1.resp_valid !== 1'b1 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk1("abort_resp.reached", bus1.resp_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk1("abort_resp.valid", bus1.resp_valid, 1'b0);
        chk("abort_resp.rdata", bus1.resp_rdata, 32'd0);
        chk1("abort_resp.ready", bus1.req_ready, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        txn("first_after_rst", 1'b0, 32'h0000_FFFC, 32'h0, 1'b0, 32'hCAFE_F00D, 0, 1'b0);

        // LATENCY=1, resp_ready tied high, req_valid held high.
        for (int e = 0; e < 18; e++) begin
            int k;
            k = e / 3;
            @(negedge clk);
            if (e % 3 == 0) begin
                bus2.req_valid = 1'b1;
                bus2.req_write = (k % 2 == 0);
                bus2.req_addr  = 32'h40;
                bus2.req_wdata = 32'h1000_0000 + 32'(k);
            end
            @(posedge clk); #1;
            chk1($sformatf("b2b.e%0d.ready", e), bus2.req_ready, (e % 3 == 2));
            chk1($sformatf("b2b.e%0d.valid", e), bus2.resp_valid, (e % 3 == 1));
            if (e % 3 == 1)
                chk($sformatf("b2b.e%0d.rdata", e), bus2.resp_rdata,
                    (k % 2 == 0) ? 32'd0 : 32'h1000_0000 + 32'(k - 1));
        end
        @(negedge clk);
        bus2.req_valid = 1'b0;

        // Randomized traffic against the word-array model.
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            txn($sformatf("rinit%0d", i), 1'b1, 32'h100 + 32'(4 * i), d, 1'b0, 32'h0, 0, 1'b0);
            model[i] = d;
        end
        for (int n = 0; n < 60; n++) begin
            wr  = 1'($urandom % 2);
            d   = $urandom;
            sel = int'($urandom % 10);
            idx = int'($urandom % 8);
            if (sel < 7) begin
                a = 32'h100 + 32'(4 * idx);
                xerr = 1'b0;
            end else if (sel < 9) begin
                a = 32'h100 + 32'(4 * idx) + 32'($urandom_range(1, 3));
                xerr = 1'b1;
            end else begin
                a = ($urandom | 32'h0001_0000) & 32'hFFFF_FFFC;
                xerr = 1'b1;
            end
            xrd = (xerr || wr) ? 32'd0 : model[idx];
            txn($sformatf("rnd%0d", n), wr, a, d, xerr, xrd, int'($urandom % 3), 1'b0);
            if (!xerr && wr) model[idx] = d;
        end
        for (int i = 0; i < 8; i++)
            txn($sformatf("rfinal%0d", i), 1'b0, 32'h100 + 32'(4 * i), 32'h0,
                1'b0, model[i], 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
